// File: rtl/eth_frame_checker.sv
// AXI-Stream checker for synthetic Ethernet/IP test frames: two header beats, then a
// counter-pattern payload. Reports per-frame status and keeps saturating good/bad counts.
module eth_frame_checker #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned KEEP_WIDTH  = 8,
    parameter logic [47:0] EXP_DST_MAC = 48'h1,
    parameter logic [47:0] EXP_SRC_MAC = 48'h2,
    parameter logic [3:0]  EXP_VERSION = 4'd4,
    parameter logic [3:0]  EXP_IHL     = 4'd5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  stall,
    output logic                  frame_done,
    output logic                  frame_ok,
    output logic [4:0]            err_code,
    output logic [15:0]           frame_len,
    output logic [31:0]           good_count,
    output logic [31:0]           bad_count
);

    typedef enum logic [1:0] {StHdr0, StHdr1, StPayload} state_e;

    state_e      state_q, state_d;
    logic        tready_q;
    logic [55:0] offset_q, offset_d;
    logic [15:0] byte_count_q, byte_count_d;
    logic [15:0] len_field_q, len_field_d;
    logic [4:0]  err_q, err_d;
    logic        frame_done_q, frame_ok_q;
    logic [4:0]  err_code_q;
    logic [15:0] frame_len_q;
    logic [31:0] good_count_q, bad_count_q;

    logic                  accept;
    logic [4:0]            beat_err;
    logic [4:0]            frame_err;
    logic [15:0]           keep_pop;
    logic [16:0]           byte_sum;
    logic [15:0]           byte_count_next;
    logic [KEEP_WIDTH-1:0] keep_inc;
    logic [63:0]           exp_word;

    assign accept   = s_axis_tvalid && tready_q;
    assign keep_inc = s_axis_tkeep + {{(KEEP_WIDTH-1){1'b0}}, 1'b1};
    assign exp_word = {8'h00, offset_q};

    always_comb begin
        keep_pop = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_pop = keep_pop + {15'd0, s_axis_tkeep[i]};
        end
    end

    assign byte_sum        = {1'b0, byte_count_q} + {1'b0, keep_pop};
    assign byte_count_next = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];

    always_comb begin
        beat_err     = '0;
        state_d      = state_q;
        offset_d     = offset_q;
        byte_count_d = byte_count_q;
        len_field_d  = len_field_q;
        unique case (state_q)
            StHdr0: begin
                if (s_axis_tdata[47:0] != EXP_DST_MAC ||
                    s_axis_tdata[63:48] != EXP_SRC_MAC[15:0]) beat_err[0] = 1'b1;
                if (s_axis_tkeep != '1 || s_axis_tlast) beat_err[4] = 1'b1;
                state_d = StHdr1;
            end
            StHdr1: begin
                if (s_axis_tdata[31:0] != EXP_SRC_MAC[47:16]) beat_err[0] = 1'b1;
                if (s_axis_tdata[51:48] != EXP_VERSION || s_axis_tdata[55:52] != EXP_IHL ||
                    s_axis_tdata[63:56] != 8'h00) beat_err[1] = 1'b1;
                if (s_axis_tkeep != '1 || s_axis_tlast) beat_err[4] = 1'b1;
                len_field_d = s_axis_tdata[47:32];
                state_d     = StPayload;
            end
            StPayload: begin
                for (int i = 0; i < KEEP_WIDTH; i++) begin
                    if (s_axis_tkeep[i] && s_axis_tdata[8*i +: 8] != exp_word[8*i +: 8]) begin
                        beat_err[2] = 1'b1;
                    end
                end
                if (s_axis_tlast) begin
                    // Last beat may be partial but must be non-empty and packed from byte 0.
                    if (s_axis_tkeep == '0 || (s_axis_tkeep & keep_inc) != '0) beat_err[4] = 1'b1;
                end else if (s_axis_tkeep != '1) begin
                    beat_err[4] = 1'b1;
                end
                offset_d     = offset_q + 56'd8;
                byte_count_d = byte_count_next;
            end
            default: state_d = StHdr0;
        endcase

        frame_err = err_q | beat_err;
        if (state_q == StPayload && byte_count_next != len_field_q) frame_err[3] = 1'b1;
        err_d = err_q | beat_err;

        if (!accept) begin
            state_d      = state_q;
            offset_d     = offset_q;
            byte_count_d = byte_count_q;
            len_field_d  = len_field_q;
            err_d        = err_q;
        end else if (s_axis_tlast) begin
            state_d      = StHdr0;
            offset_d     = '0;
            byte_count_d = '0;
            err_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StHdr0;
            tready_q     <= 1'b0;
            offset_q     <= '0;
            byte_count_q <= '0;
            len_field_q  <= '0;
            err_q        <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_code_q   <= '0;
            frame_len_q  <= '0;
            good_count_q <= '0;
            bad_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            tready_q     <= ~stall;
            offset_q     <= offset_d;
            byte_count_q <= byte_count_d;
            len_field_q  <= len_field_d;
            err_q        <= err_d;
            frame_done_q <= 1'b0;
            if (accept && s_axis_tlast) begin
                frame_done_q <= 1'b1;
                err_code_q   <= frame_err;
                frame_ok_q   <= (frame_err == '0);
                // Runts never reach payload, so byte_count_q is still zero here.
                frame_len_q  <= (state_q == StPayload) ? byte_count_next : byte_count_q;
                if (frame_err == '0) begin
                    if (good_count_q != '1) good_count_q <= good_count_q + 32'd1;
                end else begin
                    if (bad_count_q != '1) bad_count_q <= bad_count_q + 32'd1;
                end
            end
        end
    end

    assign s_axis_tready = tready_q;
    assign frame_done    = frame_done_q;
    assign frame_ok      = frame_ok_q;
    assign err_code      = err_code_q;
    assign frame_len     = frame_len_q;
    assign good_count    = good_count_q;
    assign bad_count     = bad_count_q;

endmodule

// File: tb/tb_eth_frame_checker.sv
// Directed bench for eth_frame_checker: nominal, backpressure, payload/header/length errors,
// runt and bad-tkeep frames, and reset mid-frame. Inputs driven and outputs sampled on negedge.
module tb_eth_frame_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        stall;
    logic        frame_done;
    logic        frame_ok;
    logic [4:0]  err_code;
    logic [15:0] frame_len;
    logic [31:0] good_count;
    logic [31:0] bad_count;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int exp_good = 0;
    int exp_bad = 0;
    int done_before;
    bit stall_en = 1'b0;
    int stall_phase = 0;

    eth_frame_checker dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .stall        (stall),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .err_code     (err_code),
        .frame_len    (frame_len),
        .good_count   (good_count),
        .bad_count    (bad_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    // Toggle stall every 3 cycles and confirm tready follows ~stall one cycle later.
    always @(negedge clk) begin
        if (stall_en) begin
            chk("tready_tracks_stall", {31'd0, s_axis_tready}, {31'd0, ~stall});
            stall_phase++;
            if (stall_phase == 3) begin
                stall = ~stall;
                stall_phase = 0;
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $error("FAIL handshake_timeout: observed=tready_low expected=tready_high");
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] len, input int nbytes,
                              input int bad_beat, input logic [7:0] last_keep, input bit runt);
        int nbeats;
        int rem;
        logic [63:0] d;
        logic [7:0]  k;
        send_beat({16'h0002, dst}, 8'hFF, 1'b0);
        send_beat({8'h00, 4'h5, 4'h4, len, 32'h0}, 8'hFF, runt);
        if (!runt) begin
            nbeats = (nbytes + 7) / 8;
            rem    = nbytes % 8;
            for (int b = 0; b < nbeats; b++) begin
                d = {8'h00, 56'(b * 8)};
                if (b == bad_beat) d = d + 64'd1;
                k = 8'hFF;
                if (b == nbeats - 1) begin
                    if (rem != 0) k = 8'hFF >> (8 - rem);
                    if (last_keep != 8'h00) k = last_keep;
                end
                send_beat(d, k, b == nbeats - 1);
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [4:0] exp_err,
                               input logic [15:0] exp_len);
        chk({tag, "_done"}, {31'd0, frame_done}, 32'd1);
        chk({tag, "_err"}, {27'd0, err_code}, {27'd0, exp_err});
        chk({tag, "_ok"}, {31'd0, frame_ok}, {31'd0, exp_err == 5'd0});
        chk({tag, "_len"}, {16'd0, frame_len}, {16'd0, exp_len});
        if (exp_err == 5'd0) exp_good++;
        else exp_bad++;
        chk({tag, "_good"}, good_count, exp_good);
        chk({tag, "_bad"}, bad_count, exp_bad);
        @(negedge clk);
        chk({tag, "_pulse_one_cycle"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_ok", {31'd0, frame_ok}, 32'd0);
        chk("rst_err", {27'd0, err_code}, 32'd0);
        chk("rst_len", {16'd0, frame_len}, 32'd0);
        chk("rst_good", good_count, 32'd0);
        chk("rst_bad", bad_count, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, s_axis_tready}, 32'd1);

        send_frame(48'h1, 16'd220, 220, -1, 8'h00, 1'b0);
        check_frame("nominal", 5'b00000, 16'd220);

        stall_en = 1'b1;
        send_frame(48'h1, 16'd220, 220, -1, 8'h00, 1'b0);
        check_frame("stall", 5'b00000, 16'd220);
        stall_en = 1'b0;
        stall = 1'b0;
        @(negedge clk);

        send_frame(48'h1, 16'd220, 220, 5, 8'h00, 1'b0);
        check_frame("payload_err", 5'b00100, 16'd220);
        send_frame(48'h1, 16'd220, 220, -1, 8'h00, 1'b0);
        check_frame("clean_after_err", 5'b00000, 16'd220);

        send_frame(48'h3, 16'd220, 220, -1, 8'h00, 1'b0);
        check_frame("dst_mac", 5'b00001, 16'd220);
        send_frame(48'h1, 16'd212, 220, -1, 8'h00, 1'b0);
        check_frame("len_mismatch", 5'b01000, 16'd220);
        send_frame(48'h3, 16'd212, 220, -1, 8'h00, 1'b0);
        check_frame("dst_and_len", 5'b01001, 16'd220);

        send_frame(48'h1, 16'd220, 0, -1, 8'h00, 1'b1);
        check_frame("runt_hdr1", 5'b10000, 16'd0);
        send_frame(48'h1, 16'd220, 220, -1, 8'h0B, 1'b0);
        check_frame("last_keep_0b", 5'b11000, 16'd219);

        // Partial frame cut by reset must be dropped and never reported.
        done_before = done_cnt;
        send_beat({16'h0002, 48'h1}, 8'hFF, 1'b0);
        send_beat({8'h00, 4'h5, 4'h4, 16'd220, 32'h0}, 8'hFF, 1'b0);
        send_beat(64'd0, 8'hFF, 1'b0);
        send_beat(64'd8, 8'hFF, 1'b0);
        s_axis_tvalid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_good = 0;
        exp_bad = 0;
        chk("midrst_good", good_count, 32'd0);
        chk("midrst_bad", bad_count, 32'd0);
        chk("midrst_done", {31'd0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst_no_pulse", done_cnt, done_before);
        send_frame(48'h1, 16'd220, 220, -1, 8'h00, 1'b0);
        check_frame("after_reset", 5'b00000, 16'd220);
        #1;
        chk("after_reset_pulses", done_cnt, done_before + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_frame_checker.md
Name: eth_frame_checker

Overview:
AXI-Stream slave that consumes the synthetic Ethernet/IP test frames produced by the MAC test-pattern engine on its rx stream. Each frame is two header beats followed by counter-pattern payload. The block checks every field, counts good and bad frames, and reports per-frame status. It sits opposite the engine in the KC705 loopback bench and in simulation.

Parameters:
DATA_WIDTH, 64, stream data width (only 64 supported)
KEEP_WIDTH, 8, tkeep width (DATA_WIDTH/8)
EXP_DST_MAC, 48'h1, expected destination MAC
EXP_SRC_MAC, 48'h2, expected source MAC
EXP_VERSION, 4'd4, expected IP version nibble
EXP_IHL, 4'd5, expected IHL nibble

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  stream data
s_axis_tkeep  in  KEEP_WIDTH  byte enables
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  last beat of frame
s_axis_tready  out  1  registered ready
stall  in  1  forces tready low from the next cycle (backpressure test)
frame_done  out  1  one-cycle pulse per completed frame
frame_ok  out  1  frame passed all checks; valid while frame_done=1
err_code  out  5  error flags for the frame; valid while frame_done=1
frame_len  out  16  payload byte count of the last frame
good_count  out  32  frames with no error, saturating
bad_count  out  32  frames with any error, saturating

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: s_axis_tready=0, frame_done=0, frame_ok=0, err_code=0, frame_len=0, good_count=0, bad_count=0. State returns to HDR0. Payload offset, byte count and the error accumulator are cleared.
- Reset mid-frame: the partial frame is discarded and not counted. The next accepted beat is treated as HDR0.
- Ready: s_axis_tready <= ~stall every non-reset cycle, so it follows stall with 1-cycle latency.
- A beat is accepted only when tvalid && tready. State and checks do not advance without acceptance. tdata, tkeep and tlast are ignored when there is no handshake.
- States and transitions:
  - HDR0 -> HDR1 on an accepted beat.
  - HDR1 -> PAYLOAD on an accepted beat.
  - PAYLOAD stays in PAYLOAD until tlast.
  - Any state -> HDR0 on an accepted beat with tlast, which also completes the frame.
- HDR0 checks:
  - data[47:0] must equal EXP_DST_MAC and data[63:48] must equal EXP_SRC_MAC[15:0]; mismatch sets err bit0.
  - tkeep must be FF; otherwise set bit4.
- HDR1 checks:
  - data[31:0] must equal EXP_SRC_MAC[47:16]; mismatch sets bit0.
  - data[47:32] is latched as len_field.
  - data[51:48] must equal EXP_VERSION, data[55:52] must equal EXP_IHL and data[63:56] must be 0; any mismatch sets bit1.
  - tkeep must be FF; otherwise set bit4.
- Runt: tlast in HDR0 or HDR1 sets bit4 and completes the frame.
- PAYLOAD checks, per beat:
  - Expected value = {8'h0, offset[55:0]}, with offset starting at 0 and incrementing by 8 per beat (wraps mod 2^56).
  - Only bytes whose tkeep bit is set are compared; any mismatch sets bit2.
  - byte_count (16-bit, saturating at FFFF) adds popcount(tkeep).
  - Non-last beats must have tkeep=FF.
  - The last beat's tkeep must be non-zero and contiguous from bit0, i.e. (tkeep & (tkeep+1))==0.
  - A tkeep violation sets bit4.
- Frame completion, evaluated on the tlast beat including that beat's checks:
  - If the frame reached PAYLOAD, byte_count != len_field sets bit3.
  - Outputs register one cycle after the tlast acceptance:
    - frame_done=1 for exactly one cycle.
    - err_code = accumulated flags.
    - frame_ok = (err_code==0).
    - frame_len = byte_count (0 for runts).
    - good_count or bad_count increments, holding at FFFFFFFF.
  - The accumulator, offset and byte_count clear for the next frame.
- Back-to-back frames with no idle cycle are supported; a new HDR0 beat may be accepted on the cycle that frame_done is high.
- Errors do not stop parsing; the block keeps consuming beats until tlast.

Test Plan:
- Nominal 220-byte frame (dst=1, src=2, len=220, ver=4, IHL=5; 27 FF beats with data 0..208; last beat data 216, tkeep=0F, tlast) -> frame_done pulse 1 cycle after last, frame_ok=1, err_code=0, frame_len=220, good_count=1.
- Same frame with stall toggled every 3 cycles and tvalid held -> identical result; tready tracks ~stall with 1-cycle lag; no beat lost or duplicated.
- Payload beat 5 data = 0x29 instead of 0x28 -> err_code=00100, frame_ok=0, bad_count=1; the following clean frame gives good_count=1.
- HDR0 dst MAC = 3 -> err_code bit0; len_field=212 with 220 bytes sent -> err_code bit3; both in the same frame -> err_code=01001.
- tlast on HDR1 -> err_code=10000, frame_len=0; separately, last-beat tkeep=0B -> bit4 set.
- reset asserted for 1 cycle mid-payload, then a full clean frame -> counters 0 after reset, no frame_done for the partial frame, good_count=1 after the clean frame.
